// File: rtl/vga_defs.sv
// Shared definitions for the push/switch conditioning path: parameter defaults,
// the per-button FSM encoding and the counter sizing helper.
package vga_defs;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms at 50 MHz
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms before first repeat
    localparam int DEF_REPEAT_RATE     = 5000000;   // 100 ms between repeats
    localparam int DEF_REPEAT_EN       = 1;

    typedef enum logic [1:0] {
        RELEASED   = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_e;

    // Counters only ever reach (largest period - 1), so clog2 of it is enough.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: debounce FSM, debounced level, press/release pulses
// and optional auto-repeat while the button stays held.
module debounce_channel
    import vga_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    output logic db,
    output logic press,
    output logic rel
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    db_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   rcnt_q, rcnt_d;
    logic            first_q, first_d;
    logic            db_q, db_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            hold_step;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        first_d   = first_q;
        db_d      = db_q;
        press_d   = 1'b0;
        rel_d     = 1'b0;
        hold_step = 1'b0;
        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = DB_PRESS;
                    cnt_d   = '0;
                end
            end
            DB_PRESS: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    db_d    = 1'b1;
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = DB_RELEASE;
                    cnt_d   = '0;
                end else begin
                    hold_step = 1'b1;
                end
            end
            DB_RELEASE: begin
                // A high sample here is a glitch: the held time keeps running.
                if (s) begin
                    state_d   = PRESSED;
                    hold_step = 1'b1;
                end else if (cnt_q == DB_LAST) begin
                    state_d = RELEASED;
                    db_d    = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase

        if (REPEAT_EN != 0 && hold_step) begin
            if (rcnt_q == (first_q ? DELAY_LAST : RATE_LAST)) begin
                press_d = 1'b1;
                rcnt_d  = '0;
                first_d = 1'b0;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            first_q <= 1'b1;
            db_q    <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
            db_q    <= db_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign db    = db_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/push_conditioner.sv
// Conditions the raw board buttons and switches: 2-FF synchronizers for all
// inputs, then one debounce/auto-repeat channel per push button.
module push_conditioner
    import vga_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int REPEAT_EN       = DEF_REPEAT_EN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] push,
    input  logic [2:0] switch,
    output logic [3:0] push_db,
    output logic [3:0] push_press,
    output logic [3:0] push_release,
    output logic [2:0] switch_sync
);

    logic [3:0] push_meta_q, push_meta_d;
    logic [3:0] push_sync_q, push_sync_d;
    logic [2:0] sw_meta_q, sw_meta_d;
    logic [2:0] switch_sync_q, switch_sync_d;

    always_comb begin
        push_meta_d   = push;
        push_sync_d   = push_meta_q;
        sw_meta_d     = switch;
        switch_sync_d = sw_meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_meta_q   <= '0;
            push_sync_q   <= '0;
            sw_meta_q     <= '0;
            switch_sync_q <= '0;
        end else begin
            push_meta_q   <= push_meta_d;
            push_sync_q   <= push_sync_d;
            sw_meta_q     <= sw_meta_d;
            switch_sync_q <= switch_sync_d;
        end
    end

    assign switch_sync = switch_sync_q;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .REPEAT_EN      (REPEAT_EN)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .s    (push_sync_q[i]),
            .db   (push_db[i]),
            .press(push_press[i]),
            .rel  (push_release[i])
        );
    end

endmodule

// File: doc/push_conditioner.md
PUSH_CONDITIONER -- requirements
Module: push_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning stable-input cycles required to accept a change (20 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, meaning cycles a button is held before the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_RATE, default 5000000, meaning cycles between later auto-repeat pulses.
REQ-004 SHALL have parameter REPEAT_EN, default 1, meaning auto-repeat enabled (0 = disabled).
REQ-005 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port push  input  4  raw asynchronous push buttons, active-high.
REQ-008 SHALL have port switch  input  3  raw asynchronous slide switches.
REQ-009 SHALL have port push_db  output  4  debounced button level, feeds pixelGeneration push.
REQ-010 SHALL have port push_press  output  4  one-cycle pulse per accepted press and per auto-repeat.
REQ-011 SHALL have port push_release  output  4  one-cycle pulse per accepted release.
REQ-012 SHALL have port switch_sync  output  3  switch after 2-FF synchronizer, feeds pixelGeneration switch.

Function
REQ-013 SHALL pass each push and switch bit through a 2-FF synchronizer; s[i] is the second FF output.
REQ-014 SHALL run one independent FSM per push bit with states RELEASED, DB_PRESS, PRESSED, DB_RELEASE.
REQ-015 SHALL, in RELEASED with s=1, go to DB_PRESS with debounce count 0; s=0 stays.
REQ-016 SHALL, in DB_PRESS, increment count while s=1; s=0 returns to RELEASED, no pulse.
REQ-017 SHALL, in DB_PRESS with count==DEBOUNCE_CYCLES-1 and s=1, go to PRESSED, set push_db=1, pulse push_press, clear repeat count.
REQ-018 SHALL give press latency: push sampled high at edge 0 and held -> push_press high the cycle after edge DEBOUNCE_CYCLES+2.
REQ-019 SHALL, in PRESSED with s=0, go to DB_RELEASE with debounce count 0, repeat count frozen.
REQ-020 SHALL, in DB_RELEASE, return to PRESSED on s=1 (glitch ignored, no pulse, repeat count resumes); with count==DEBOUNCE_CYCLES-1 and s=0, go to RELEASED, clear push_db, pulse push_release.
REQ-021 SHALL, when REPEAT_EN=1 and in PRESSED, pulse push_press REPEAT_DELAY cycles after PRESSED entry, then every REPEAT_RATE cycles while held.
REQ-022 SHALL size counters to clog2 of the largest parameter; no wrap before terminal count; repeat count reloads after each repeat pulse.
REQ-023 SHALL register all outputs; pulses exactly one cycle; press and release pulses never coincide on one bit.
REQ-024 SHALL keep channels independent; simultaneous presses on several bits pulse in the same cycle.
REQ-025 SHALL treat DEBOUNCE_CYCLES=1 as acceptance after a single stable sample (no underflow).

Reset
REQ-026 SHALL, on rst=0, asynchronously clear synchronizers, counters, FSMs to RELEASED, and push_db, push_press, push_release, switch_sync to 0.
REQ-027 SHALL, if reset occurs mid-debounce or mid-hold, emit no release pulse; a still-held button is re-debounced from RELEASED after rst=1.

Structure
REQ-028 SHALL place FSM state encodings and default parameter values in the shared vga_defs include file.
REQ-029 SHALL implement one sub-module, debounce_channel (one FSM plus counters), instantiated four times; synchronizers in push_conditioner.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-030 SHALL check clean press: push[0] high from edge 0 -> push_db[0]=1 and push_press[0] pulse after edge 6; no other bits change.
REQ-031 SHALL check bounce: push[1] high 2 cycles, low 1, then held -> one press pulse only, 6 edges after final rise.
REQ-032 SHALL check auto-repeat: push[2] held 30 cycles -> press pulses after edges 6, 16, 19, 22, 25, 28; release pulse 6 edges after drop; REPEAT_EN=0 -> edge 6 pulse only.
REQ-033 SHALL check release glitch: held push[3] drops 2 cycles -> push_db[3] stays 1, no release pulse, repeat timing shifted by 2 cycles.
REQ-034 SHALL check reset mid-hold: rst=0 while push_db=4'b1111 -> all outputs 0 immediately, no release pulses; buttons still held -> presses re-accepted 6 edges after rst=1.
REQ-035 SHALL check switch: switch=3'b101 applied -> switch_sync=3'b101 after 2 edges.
